lc3_op_sequencer: RTL and testbench

- Multi-cycle controller that executes LC-3 operate instructions (ADD, AND, NOT) on the shared 16-bit ALU and bus.
- Latches an instruction on a start handshake, then drives the register-file source/destination selects, the ALU function code and immediate slice, and the ALU bus gate.
- Pulses register and condition-code loads, and maintains the NZP condition register from the bus value.
- Sits between instruction fetch/decode and the datapath (regfile, ALU, bus).

---
 rtl/lc3_pkg.sv | 35 +++
 rtl/lc3_nzp_gen.sv | 17 +
 rtl/lc3_op_sequencer.sv | 94 +++++++++
 tb/tb_lc3_op_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 operate-instruction sequencer: opcodes, ALU
// function codes, FSM state encoding and the condition-code reset value.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_XOR  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_DECODE = 2'b01;
  localparam logic [1:0] ST_EXEC   = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  localparam logic [2:0] NZP_RESET = 3'b010;

  function automatic logic is_operate(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // NOT is an XOR against the all-ones immediate carried in the instruction.
  function automatic logic [1:0] op_to_aluk(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALUK_ADD;
      OP_AND:  return ALUK_AND;
      OP_NOT:  return ALUK_XOR;
      default: return ALUK_PASS;
    endcase
  endfunction

endpackage

// File: rtl/lc3_nzp_gen.sv
// Combinational bus value to one-hot {n,z,p} condition code.
// Zero latency; no flow control.
module lc3_nzp_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] bus,
  output logic [2:0]       nzp
);

  logic n;
  logic z;

  assign n   = bus[WIDTH-1];
  assign z   = (bus == '0);
  assign nzp = {n, z, !n && !z};

endmodule

// File: rtl/lc3_op_sequencer.sv
// Multi-cycle sequencer for LC-3 ADD/AND/NOT on the shared ALU and bus.
// done at start+2+SETTLE (legal) or start+2 (illegal); start is ignored while busy.
module lc3_op_sequencer
  import lc3_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      ir,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic [2:0]       dr,
  output logic [1:0]       aluk,
  output logic [5:0]       ir_slice,
  output logic             gate_alu,
  output logic             ld_reg,
  output logic             ld_cc,
  input  logic [WIDTH-1:0] bus,
  output logic [2:0]       nzp
);

  logic [1:0]  state;
  logic [15:0] ir_q;
  logic [3:0]  cnt;
  logic        illegal_q;
  logic [2:0]  nzp_next;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

  lc3_nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
    .bus (bus),
    .nzp (nzp_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ir_q      <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      nzp       <= NZP_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ir_q      <= ir;
            illegal_q <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_operate(opcode)) begin
            cnt   <= 4'(SETTLE - 1);
            state <= ST_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            nzp   <= nzp_next;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign illegal  = done && illegal_q;
  assign gate_alu = (state == ST_EXEC);
  // A reset landing on the writeback cycle must not let the strobe escape.
  assign ld_reg   = gate_alu && (cnt == '0) && !rst;
  assign ld_cc    = ld_reg;

  assign sr1      = ir_q[8:6];
  assign sr2      = ir_q[2:0];
  assign dr       = ir_q[11:9];
  assign ir_slice = ir_q[5:0];
  assign aluk     = (state == ST_IDLE) ? ALUK_ADD : op_to_aluk(opcode);

endmodule

// File: tb/tb_lc3_op_sequencer.sv
// Directed bench: SETTLE=1 and SETTLE=3 instances, vector table plus
// hand-written reset-abort and back-to-back sequences.
module tb_lc3_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic [15:0] ir;
  logic [15:0] bus;

  logic       busy1, done1, ill1, gate1, ldr1, ldc1;
  logic [2:0] sr1_1, sr2_1, dr_1, nzp1;
  logic [1:0] aluk1;
  logic [5:0] sl1;
  logic       busy3, done3, ill3, gate3, ldr3, ldc3;
  logic [2:0] sr1_3, sr2_3, dr_3, nzp3;
  logic [1:0] aluk3;
  logic [5:0] sl3;

  logic       sel;
  logic       o_busy, o_done, o_ill, o_gate, o_ldr, o_ldc;
  logic [2:0] o_sr1, o_sr2, o_dr, o_nzp;
  logic [1:0] o_aluk;
  logic [5:0] o_sl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_op_sequencer #(.WIDTH(16), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ir(ir),
    .busy(busy1), .done(done1), .illegal(ill1),
    .sr1(sr1_1), .sr2(sr2_1), .dr(dr_1), .aluk(aluk1), .ir_slice(sl1),
    .gate_alu(gate1), .ld_reg(ldr1), .ld_cc(ldc1), .bus(bus), .nzp(nzp1)
  );

  lc3_op_sequencer #(.WIDTH(16), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .ir(ir),
    .busy(busy3), .done(done3), .illegal(ill3),
    .sr1(sr1_3), .sr2(sr2_3), .dr(dr_3), .aluk(aluk3), .ir_slice(sl3),
    .gate_alu(gate3), .ld_reg(ldr3), .ld_cc(ldc3), .bus(bus), .nzp(nzp3)
  );

  always_comb begin
    if (sel) begin
      o_busy = busy3; o_done = done3; o_ill = ill3; o_gate = gate3;
      o_ldr = ldr3; o_ldc = ldc3; o_sr1 = sr1_3; o_sr2 = sr2_3;
      o_dr = dr_3; o_nzp = nzp3; o_aluk = aluk3; o_sl = sl3;
    end else begin
      o_busy = busy1; o_done = done1; o_ill = ill1; o_gate = gate1;
      o_ldr = ldr1; o_ldc = ldc1; o_sr1 = sr1_1; o_sr2 = sr2_1;
      o_dr = dr_1; o_nzp = nzp1; o_aluk = aluk1; o_sl = sl1;
    end
  end

  typedef struct {
    logic [15:0] ir;
    logic [15:0] bus;
    bit          use3;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic [1:0]  aluk;
    logic [5:0]  slice;
    logic [2:0]  nzp;
    bit          ill;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int settle, exp_done, done_k, ld_k, gate_n, ld_n;
    logic ill_seen, ld_bad, dr_at_done;
    settle = v.use3 ? 3 : 1;
    exp_done = v.ill ? 2 : 2 + settle;
    done_k = -1; ld_k = -1; gate_n = 0; ld_n = 0;
    ill_seen = 1'b0; ld_bad = 1'b0; dr_at_done = 1'b0;
    sel = v.use3;
    ir = v.ir; bus = v.bus;
    if (v.use3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), o_busy, 1'b0);
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_dec_busy", idx), o_busy, 1'b1);
    check($sformatf("v%0d_sr1", idx), o_sr1, v.sr1);
    check($sformatf("v%0d_sr2", idx), o_sr2, v.sr2);
    check($sformatf("v%0d_dr", idx), o_dr, v.dr);
    check($sformatf("v%0d_slice", idx), o_sl, v.slice);
    if (!v.ill) check($sformatf("v%0d_aluk", idx), o_aluk, v.aluk);
    check($sformatf("v%0d_dec_gate", idx), o_gate, 1'b0);
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_gate) gate_n++;
      if (o_ldr) begin
        ld_n++; ld_k = k;
        if (!o_gate) ld_bad = 1'b1;
      end
      if (o_ldc !== o_ldr) ld_bad = 1'b1;
      if (o_done) begin
        done_k = k; ill_seen = o_ill; dr_at_done = (o_dr === v.dr);
        break;
      end
    end
    check($sformatf("v%0d_done_cycle", idx), done_k, exp_done);
    check($sformatf("v%0d_illegal", idx), ill_seen, v.ill);
    check($sformatf("v%0d_gate_cycles", idx), gate_n, v.ill ? 0 : settle);
    check($sformatf("v%0d_ld_cycles", idx), ld_n, v.ill ? 0 : 1);
    check($sformatf("v%0d_ld_strobe_ok", idx), ld_bad, 1'b0);
    check($sformatf("v%0d_dr_held", idx), dr_at_done, 1'b1);
    if (!v.ill) check($sformatf("v%0d_ld_cycle", idx), ld_k, exp_done - 1);
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d_post_busy", idx), o_busy, 1'b0);
    check($sformatf("v%0d_post_aluk", idx), o_aluk, 2'b00);
    check($sformatf("v%0d_nzp", idx), o_nzp, v.nzp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic exp_busy, exp_gate, exp_ld, exp_done, bad;

    //             ir        bus       use3  sr1   sr2   dr    aluk   slice      nzp     ill
    vecs[0] = '{16'h1042, 16'h0005, 1'b0, 3'd1, 3'd2, 3'd0, 2'b00, 6'b000010, 3'b001, 1'b0};
    vecs[1] = '{16'h5660, 16'h0000, 1'b0, 3'd1, 3'd0, 3'd3, 2'b01, 6'b100000, 3'b010, 1'b0};
    vecs[2] = '{16'h927F, 16'h8000, 1'b0, 3'd1, 3'd7, 3'd1, 2'b10, 6'b111111, 3'b100, 1'b0};
    vecs[3] = '{16'h0E00, 16'h0001, 1'b0, 3'd0, 3'd0, 3'd7, 2'b00, 6'b000000, 3'b100, 1'b1};
    vecs[4] = '{16'h1FFF, 16'h7FFF, 1'b1, 3'd7, 3'd7, 3'd7, 2'b00, 6'b111111, 3'b001, 1'b0};

    sel = 1'b0; rst = 1'b1; start1 = 1'b0; start3 = 1'b0; ir = '0; bus = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_hold_busy", busy1, 1'b0);
    check("rst_hold_nzp", nzp1, 3'b010);
    rst = 1'b0;
    @(negedge clk);
    check("rst_nzp1", nzp1, 3'b010);
    check("rst_nzp3", nzp3, 3'b010);
    check("rst_busy", {busy1, busy3}, 2'b00);
    check("rst_strobes", {done1, ill1, gate1, ldr1, ldc1}, 5'b0);
    check("rst_selects", {sr1_1, sr2_1, dr_1, aluk1, sl1}, 17'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // SETTLE=3, start held high: second instruction taken the cycle after done.
    sel = 1'b1; bus = 16'h0005;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) begin start3 = 1'b1; ir = 16'h1042; end
      if (c == 1) ir = 16'h5660;
      if (c == 7) start3 = 1'b0;
      @(negedge clk);
      exp_busy = (c >= 1 && c <= 5) || (c >= 7 && c <= 11);
      exp_gate = (c >= 2 && c <= 4) || (c >= 8 && c <= 10);
      exp_ld   = (c == 4) || (c == 10);
      exp_done = (c == 5) || (c == 11);
      check($sformatf("b2b_c%0d_busy", c), busy3, exp_busy);
      check($sformatf("b2b_c%0d_gate", c), gate3, exp_gate);
      check($sformatf("b2b_c%0d_ld", c), {ldr3, ldc3}, {exp_ld, exp_ld});
      check($sformatf("b2b_c%0d_done", c), done3, exp_done);
      if (c >= 1 && c <= 5) check($sformatf("b2b_c%0d_dr", c), dr_3, 3'd0);
      if (c >= 7 && c <= 11) check($sformatf("b2b_c%0d_dr", c), dr_3, 3'd3);
      if (c == 7) check("b2b_c7_aluk", aluk3, 2'b01);
      @(posedge clk); #1;
    end
    check("b2b_nzp", nzp3, 3'b001);

    // Reset during the first EXEC cycle of a SETTLE=3 op must abort it.
    bus = 16'h8000; ir = 16'h1042; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_exec", gate3, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy3, 1'b0);
    check("abort_gate", gate3, 1'b0);
    check("abort_nzp", nzp3, 3'b010);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ldr3 || ldc3 || done3 || gate3) bad = 1'b1;
    end
    check("abort_no_pulse", bad, 1'b0);
    check("abort_nzp_after", nzp3, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
